// File: rtl/gray_pkg.sv
// Gray-code helpers shared by the reader-side receiver and the writer-side gray counter.
// Functions work on a 32-bit word; callers size-cast to their own pointer width.
package gray_pkg;

    localparam int unsigned MAX_W      = 32;
    localparam int unsigned LENGTH_DEF = 8;

    typedef logic [MAX_W-1:0] word_t;

    function automatic int unsigned ptr_w(int unsigned length);
        return length;
    endfunction

    function automatic int unsigned addr_w(int unsigned length);
        return length - 1;
    endfunction

    typedef logic [ptr_w(LENGTH_DEF)-1:0]  ptr_t;
    typedef logic [addr_w(LENGTH_DEF)-1:0] addr_t;

    function automatic word_t bin2gray(word_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended inputs decode correctly because the leading zeros xor away.
    function automatic word_t gray2bin(word_t g);
        word_t b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic int unsigned popcount(word_t v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_W; i++) n += 32'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/gray_pointer_receiver_if.sv
// Pop/status bundle of the read-side gray pointer receiver.
// master = reader logic driving pops, slave = the receiver.
interface gray_pointer_receiver_if #(
    parameter int unsigned LENGTH = 8
);
    logic [LENGTH-1:0] gray_in;
    logic              rd_en;
    logic              rd_ack;
    logic [LENGTH-2:0] rd_addr;
    logic [LENGTH-1:0] rd_ptr_gray;
    logic [LENGTH-1:0] binary_remote;
    logic [LENGTH-1:0] level;
    logic              empty;
    logic              overflow;
    logic              gray_err;

    modport master (
        output gray_in, rd_en,
        input  rd_ack, rd_addr, rd_ptr_gray, binary_remote, level, empty, overflow, gray_err
    );

    modport slave (
        input  gray_in, rd_en,
        output rd_ack, rd_addr, rd_ptr_gray, binary_remote, level, empty, overflow, gray_err
    );
endinterface

// File: rtl/gray_sync_chain.sv
// Plain flop chain synchronizer for a gray-coded bus; no logic between stages.
module gray_sync_chain #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_q <= '0;
        else        r_q <= {r_q[SYNC_STAGES-2:0], i_d};
    end

    assign o_q = r_q[SYNC_STAGES-1];
endmodule

// File: rtl/gray_pointer_receiver.sv
// Read-domain end of the async FIFO gray pointer crossing: sync, decode, read pointer, status.
// Optional GRAY_CHECK_EN adds a multi-bit gray step detector on the synchronized pointer.
module gray_pointer_receiver
    import gray_pkg::*;
#(
    parameter int unsigned LENGTH      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk_diff,
    input  logic                   reset_diff_n,
    gray_pointer_receiver_if.slave bus
);
    localparam logic [LENGTH-1:0] HALF = {1'b1, {(LENGTH-1){1'b0}}};

    logic [LENGTH-1:0] w_gray_s, w_remote_next, w_rd_ptr_next, w_level_next;
    logic              w_accept;

    logic [LENGTH-1:0] r_rd_ptr, r_rd_ptr_gray, r_binary_remote, r_level;
    logic              r_rd_ack, r_empty, r_overflow;

    gray_sync_chain #(.WIDTH(LENGTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk_diff),
        .rst_n (reset_diff_n),
        .i_d   (bus.gray_in),
        .o_q   (w_gray_s)
    );

    // Status is derived from next-state values so level, empty and rd_ptr never disagree.
    always_comb begin
        w_remote_next = LENGTH'(gray2bin(word_t'(w_gray_s)));
        w_accept      = bus.rd_en & ~r_empty;
        w_rd_ptr_next = r_rd_ptr + {{(LENGTH-1){1'b0}}, w_accept};
        w_level_next  = w_remote_next - w_rd_ptr_next;
    end

    always_ff @(posedge clk_diff or negedge reset_diff_n) begin
        if (!reset_diff_n) begin
            r_rd_ptr        <= '0;
            r_rd_ptr_gray   <= '0;
            r_binary_remote <= '0;
            r_level         <= '0;
            r_rd_ack        <= 1'b0;
            r_empty         <= 1'b1;
            r_overflow      <= 1'b0;
        end else begin
            r_rd_ptr        <= w_rd_ptr_next;
            r_rd_ptr_gray   <= LENGTH'(bin2gray(word_t'(w_rd_ptr_next)));
            r_binary_remote <= w_remote_next;
            r_level         <= w_level_next;
            r_rd_ack        <= w_accept;
            r_empty         <= (w_level_next == '0);
            r_overflow      <= r_overflow | (w_level_next > HALF);
        end
    end

`ifdef GRAY_CHECK_EN
    logic [LENGTH-1:0] r_gray_prev;
    logic              r_gray_err;

    // Flag only; the decode path above still consumes the new value.
    always_ff @(posedge clk_diff or negedge reset_diff_n) begin
        if (!reset_diff_n) begin
            r_gray_prev <= '0;
            r_gray_err  <= 1'b0;
        end else begin
            r_gray_prev <= w_gray_s;
            r_gray_err  <= popcount(word_t'(w_gray_s ^ r_gray_prev)) > 1;
        end
    end

    assign bus.gray_err = r_gray_err;
`else
    assign bus.gray_err = 1'b0;
`endif

    assign bus.rd_ack        = r_rd_ack;
    assign bus.rd_addr       = r_rd_ptr[LENGTH-2:0];
    assign bus.rd_ptr_gray   = r_rd_ptr_gray;
    assign bus.binary_remote = r_binary_remote;
    assign bus.level         = r_level;
    assign bus.empty         = r_empty;
    assign bus.overflow      = r_overflow;
endmodule
